// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared across the pipelined MIPS core.
//   NOP_INSTR        - bubble word (sll $0,$0,0), decodes as a harmless R-type
//   RESET_PC_DEFAULT - default PC value loaded on reset
//   if_state_t       - instruction-fetch control state (1 bit, FETCH = 0)
package cpu_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } if_state_t;

endpackage

// File: rtl/if_hold_buffer.sv
// if_hold_buffer: one-entry register with load, clear and a valid flag.
// Used by the fetch stage to capture a word that returns while the
// pipeline is stalled, so it can be delivered once the stall releases.
//   clk    in   clock, rising edge
//   rst_n  in   synchronous active-low reset (empties the entry)
//   load   in   capture din, mark valid
//   clear  in   drop the entry (wins over load)
//   din    in   WIDTH-bit data to capture
//   dout   out  stored data
//   valid  out  entry holds captured data
module if_hold_buffer #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             valid
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout  <= '0;
            valid <= 1'b0;
        end else if (clear) begin
            dout  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            dout  <= din;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage of the pipelined MIPS core.
// Owns the PC, issues instruction-memory requests and loads the IF/ID
// pipeline register. Honours hazard-unit stalls and ID-stage redirects;
// a word that returns while stalled is parked in a hold buffer.
//   clk          in   clock, rising edge
//   rst_n        in   synchronous active-low reset
//   imem_req     out  fetch request, address valid while high
//   imem_addr    out  fetch address (current PC)
//   imem_ready   in   imem_rdata valid this cycle for imem_addr
//   imem_rdata   in   fetched word
//   stall        in   hold PC and IF/ID
//   redirect     in   taken branch / jump resolved in ID
//   redirect_pc  in   redirect target, bits [1:0] forced to 00
//   ifid_instr   out  IF/ID instruction
//   ifid_pc4     out  IF/ID PC+4
//   ifid_valid   out  IF/ID holds a real instruction
//   pc           out  current PC
module if_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP      = NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic [31:0] pc
);

    if_state_t   state;
    if_state_t   state_next;

    logic [31:0] pc_plus4;
    logic        buf_load;
    logic        buf_clear;
    logic [63:0] buf_data;
    logic        buf_valid;

    // Modulo-2^32 increment: 32'hFFFF_FFFC wraps to 0.
    assign pc_plus4 = pc + 32'd4;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state;
        if (redirect) begin
            state_next = FETCH;
        end else begin
            case (state)
                FETCH: if (stall && imem_ready) state_next = HOLD;
                HOLD:  if (!stall)              state_next = FETCH;
                default:                        state_next = FETCH;
            endcase
        end
    end

    // ---------------- output logic ----------------
    // Request depends only on state, pc and rst_n; never on imem_ready.
    always_comb begin
        imem_req  = rst_n && (state == FETCH);
        imem_addr = pc;
    end

    // ---------------- hold buffer ----------------
    // Capture only in FETCH with a stall and a returning word; a redirect
    // or the release from HOLD empties it.
    assign buf_load  = (state == FETCH) && stall && imem_ready && !redirect;
    assign buf_clear = redirect || ((state == HOLD) && !stall);

    if_hold_buffer #(
        .WIDTH (64)
    ) u_hold (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (buf_load),
        .clear (buf_clear),
        .din   ({imem_rdata, pc_plus4}),
        .dout  (buf_data),
        .valid (buf_valid)
    );

    // ---------------- PC and IF/ID register ----------------
    // Priority: reset, redirect, stall, normal operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            ifid_instr <= NOP;
            ifid_pc4   <= '0;
            ifid_valid <= 1'b0;
        end else if (redirect) begin
            pc         <= {redirect_pc[31:2], 2'b00};
            ifid_instr <= NOP;
            ifid_valid <= 1'b0;
        end else if (state == FETCH) begin
            if (!stall) begin
                if (imem_ready) begin
                    ifid_instr <= imem_rdata;
                    ifid_pc4   <= pc_plus4;
                    ifid_valid <= 1'b1;
                    pc         <= pc_plus4;
                end else begin
                    // Bubble; ifid_pc4 intentionally left as is.
                    ifid_instr <= NOP;
                    ifid_valid <= 1'b0;
                end
            end else if (imem_ready) begin
                // IF/ID frozen; the word goes to the hold buffer and the
                // PC advances so the next fetch is the following word.
                pc <= pc_plus4;
            end
        end else begin
            if (!stall) begin
                ifid_instr <= buf_data[63:32];
                ifid_pc4   <= buf_data[31:0];
                ifid_valid <= buf_valid;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic [31:0] pc;

    int unsigned tests;
    int unsigned fails;

    if_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .ifid_instr  (ifid_instr),
        .ifid_pc4    (ifid_pc4),
        .ifid_valid  (ifid_valid),
        .pc          (pc)
    );

    // Memory returns a word tagged with its own address.
    assign imem_rdata = imem_addr | 32'hA000_0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic        redirect;
        logic [31:0] rpc;
        logic        ready;
        logic        pre_req;
        logic        exp_req;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc4;
        logic        exp_valid;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic s, input logic rd,
                                input logic [31:0] rp, input logic rdy,
                                input logic preq, input logic req,
                                input logic [31:0] epc, input logic [31:0] ein,
                                input logic [31:0] ep4, input logic ev);
        vec_t v;
        v.rst_n = r; v.stall = s; v.redirect = rd; v.rpc = rp; v.ready = rdy;
        v.pre_req = preq; v.exp_req = req; v.exp_pc = epc;
        v.exp_instr = ein; v.exp_pc4 = ep4; v.exp_valid = ev;
        return v;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        imem_ready = 1'b0;

        //            rst stl red rpc           rdy pre  req pc            instr         pc4           v
        // reset, including redirect/stall ignored under reset
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 0,   0, 32'h0,        32'h0,        32'h0,        0));
        vecs.push_back(mk(0, 1, 1, 32'h40,       1, 0,   0, 32'h0,        32'h0,        32'h0,        0));
        // free run
        vecs.push_back(mk(1, 0, 0, 32'h0,        1, 1,   1, 32'h4,        32'hA000_0000, 32'h4,       1));
        vecs.push_back(mk(1, 0, 0, 32'h0,        1, 1,   1, 32'h8,        32'hA000_0004, 32'h8,       1));
        // stall 3 cycles at pc=8 with ready
        vecs.push_back(mk(1, 1, 0, 32'h0,        1, 1,   0, 32'hC,        32'hA000_0004, 32'h8,       1));
        vecs.push_back(mk(1, 1, 0, 32'h0,        1, 0,   0, 32'hC,        32'hA000_0004, 32'h8,       1));
        vecs.push_back(mk(1, 1, 0, 32'h0,        1, 0,   0, 32'hC,        32'hA000_0004, 32'h8,       1));
        // release: buffered word enters IF/ID, fetch resumes at C
        vecs.push_back(mk(1, 0, 0, 32'h0,        1, 0,   1, 32'hC,        32'hA000_0008, 32'hC,       1));
        vecs.push_back(mk(1, 0, 0, 32'h0,        1, 1,   1, 32'h10,       32'hA000_000C, 32'h10,      1));
        // redirect to 0x43 with stall and ready
        vecs.push_back(mk(1, 1, 1, 32'h43,       1, 1,   1, 32'h40,       32'h0,        32'h10,       0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        1, 1,   1, 32'h44,       32'hA000_0040, 32'h44,      1));
        // two wait states
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 1,   1, 32'h44,       32'h0,        32'h44,       0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 1,   1, 32'h44,       32'h0,        32'h44,       0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        1, 1,   1, 32'h48,       32'hA000_0044, 32'h48,      1));
        // wrap
        vecs.push_back(mk(1, 0, 1, 32'hFFFF_FFFC, 1, 1,  1, 32'hFFFF_FFFC, 32'h0,       32'h48,       0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        1, 1,   1, 32'h0,        32'hFFFF_FFFC, 32'h0,       1));
        // enter HOLD, then reset while in HOLD
        vecs.push_back(mk(1, 1, 0, 32'h0,        1, 1,   0, 32'h4,        32'hFFFF_FFFC, 32'h0,       1));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 0,   0, 32'h0,        32'h0,        32'h0,        0));
        // first request at RESET_PC; ready low shows buffered word is gone
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 1,   1, 32'h0,        32'h0,        32'h0,        0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        1, 1,   1, 32'h4,        32'hA000_0000, 32'h4,       1));
        // enter HOLD, then redirect out of HOLD discards the buffer
        vecs.push_back(mk(1, 1, 0, 32'h0,        1, 1,   0, 32'h8,        32'hA000_0000, 32'h4,       1));
        vecs.push_back(mk(1, 0, 1, 32'h100,      0, 0,   1, 32'h100,      32'h0,        32'h4,        0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        1, 1,   1, 32'h104,      32'hA000_0100, 32'h104,     1));
        // stall in FETCH without ready: nothing changes
        vecs.push_back(mk(1, 1, 0, 32'h0,        0, 1,   1, 32'h104,      32'hA000_0100, 32'h104,     1));
        vecs.push_back(mk(1, 0, 0, 32'h0,        1, 1,   1, 32'h108,      32'hA000_0104, 32'h108,     1));

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_n       = vecs[i].rst_n;
            stall       = vecs[i].stall;
            redirect    = vecs[i].redirect;
            redirect_pc = vecs[i].rpc;
            imem_ready  = vecs[i].ready;
            #1;
            chk("pre_req", i, {31'b0, imem_req}, {31'b0, vecs[i].pre_req});
            if (i > 0)
                chk("pre_addr", i, imem_addr, vecs[i-1].exp_pc);
            @(posedge clk);
            #1;
            chk("req",   i, {31'b0, imem_req},   {31'b0, vecs[i].exp_req});
            chk("addr",  i, imem_addr,           vecs[i].exp_pc);
            chk("pc",    i, pc,                  vecs[i].exp_pc);
            chk("instr", i, ifid_instr,          vecs[i].exp_instr);
            chk("pc4",   i, ifid_pc4,            vecs[i].exp_pc4);
            chk("valid", i, {31'b0, ifid_valid}, {31'b0, vecs[i].exp_valid});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
